// File: rtl/serial_frame_receiver.sv
// Serial-in/parallel-out frame receiver for an MSB-first shift-register link.
// Rebuilds WIDTH-bit frames on qualified ticks; hands them off with valid/ack.
module serial_frame_receiver #(
    parameter  int WIDTH = 12,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick,
    input  logic             serial_in,
    input  logic             shift_en,
    input  logic             data_ack,
    output logic [WIDTH-1:0] data,
    output logic             data_valid,
    output logic             overrun,
    output logic             frame_error,
    output logic             busy,
    output logic [CW-1:0]    bit_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;
    logic             r_ferr;
    logic [CW-1:0]    r_count;

    logic [WIDTH-1:0] w_shifted;
    logic             w_last;

    assign w_shifted = {r_acc[WIDTH-2:0], serial_in};
    assign w_last    = (r_count == CW'(WIDTH - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_ferr    <= 1'b0;
            r_count   <= '0;
        end else begin
            r_ferr <= 1'b0;
            // Ack alone clears; a completion below may re-raise valid.
            if (data_ack) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
            if (tick) begin
                unique case (r_state)
                    S_IDLE: begin
                        if (shift_en) begin
                            r_acc   <= w_shifted;
                            r_count <= CW'(1);
                            r_state <= S_RECV;
                        end else begin
                            r_count <= '0;
                        end
                    end
                    S_RECV: begin
                        if (!shift_en) begin
                            r_ferr  <= 1'b1;
                            r_count <= '0;
                            r_state <= S_IDLE;
                        end else if (w_last) begin
                            r_acc   <= w_shifted;
                            r_count <= '0;
                            r_state <= S_DRAIN;
                            if (!r_valid || data_ack) begin
                                r_data  <= w_shifted;
                                r_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_acc   <= w_shifted;
                            r_count <= r_count + CW'(1);
                        end
                    end
                    S_DRAIN: begin
                        if (!shift_en) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_count <= '0;
                    end
                endcase
            end
        end
    end

    assign data        = r_data;
    assign data_valid  = r_valid;
    assign overrun     = r_overrun;
    assign frame_error = r_ferr;
    assign busy        = (r_state != S_IDLE);
    assign bit_count   = r_count;

endmodule
